// File: rtl/pe_port_arbiter.sv
// pe_port_arbiter
// Round-robin arbiter sharing one router injection port between NUM_IN
// PE-side requesters. One requester is granted per cycle; its flit is
// registered into a single-entry output stage that hands off to the router
// with a valid/ready handshake. Flits accepted by the router are counted.
//
// rst is asynchronous and active-low: it clears the output stage (a held
// flit is dropped, not counted), the round-robin pointer and the counter.

module pe_port_arbiter #(
    parameter int NUM_IN = 4,
    parameter int DATA_W = 32,
    parameter int SRC_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN*DATA_W-1:0] i_data,
    input  logic [NUM_IN-1:0]        i_data_valid,
    output logic [NUM_IN-1:0]        o_data_ready,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_data_valid,
    output logic [SRC_W-1:0]         o_src,
    input  logic                     i_data_ready,
    output logic [31:0]              o_pkt_count
);

    localparam logic [SRC_W-1:0] SRC_ZERO = {SRC_W{1'b0}};
    localparam logic [SRC_W-1:0] SRC_ONE  = SRC_W'(32'd1);

    // Output stage and bookkeeping registers
    logic [DATA_W-1:0] data_r;
    logic              valid_r;
    logic [SRC_W-1:0]  src_r;
    logic [SRC_W-1:0]  ptr_r;
    logic [31:0]       pkt_count_r;

    // Combinational arbitration signals
    logic [DATA_W-1:0] flit_arr_s [NUM_IN];
    logic              load_en_s;
    logic              load_s;
    logic              drain_s;
    logic              any_valid_s;
    logic [SRC_W-1:0]  grant_idx_s;
    logic [SRC_W-1:0]  scan_sel_s;
    int                scan_idx_s;
    logic [SRC_W-1:0]  next_ptr_s;
    logic [DATA_W-1:0] sel_flit_s;

    // Split the packed requester bus into one flit per requester
    always_comb begin
        for (int k = 0; k < NUM_IN; k++) begin
            flit_arr_s[k] = i_data[k*DATA_W +: DATA_W];
        end
    end

    // The stage may take a new flit when it is empty or being drained now.
    // When the stage is empty this is 1 regardless of i_data_ready.
    always_comb begin
        load_en_s = ~valid_r | i_data_ready;
        drain_s   = valid_r & i_data_ready;
    end

    // Round-robin scan starting at ptr_r, wrapping modulo NUM_IN
    always_comb begin
        any_valid_s = 1'b0;
        grant_idx_s = SRC_ZERO;
        scan_idx_s  = 32'sd0;
        scan_sel_s  = SRC_ZERO;
        for (int i = 0; i < NUM_IN; i++) begin
            scan_idx_s = int'(ptr_r) + i;
            scan_idx_s = (scan_idx_s >= NUM_IN) ? (scan_idx_s - NUM_IN) : scan_idx_s;
            scan_sel_s = scan_idx_s[SRC_W-1:0];
            if (!any_valid_s && i_data_valid[scan_sel_s]) begin
                any_valid_s = 1'b1;
                grant_idx_s = scan_sel_s;
            end else begin
                any_valid_s = any_valid_s;
            end
        end
    end

    // Granted flit, load strobe and the pointer value after this grant
    always_comb begin
        sel_flit_s = flit_arr_s[grant_idx_s];
        load_s     = load_en_s & any_valid_s;
        if (int'(grant_idx_s) == (NUM_IN - 1)) begin
            next_ptr_s = SRC_ZERO;
        end else begin
            next_ptr_s = grant_idx_s + SRC_ONE;
        end
    end

    // One-hot ready towards the granted requester only
    always_comb begin
        o_data_ready = {NUM_IN{1'b0}};
        if (load_s) begin
            o_data_ready[grant_idx_s] = 1'b1;
        end else begin
            o_data_ready = {NUM_IN{1'b0}};
        end
    end

    // Output stage: load granted flit, empty on drain without refill, else hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_r  <= {DATA_W{1'b0}};
            src_r   <= SRC_ZERO;
            valid_r <= 1'b0;
        end else if (load_s) begin
            data_r  <= sel_flit_s;
            src_r   <= grant_idx_s;
            valid_r <= 1'b1;
        end else if (load_en_s) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Pointer moves past the winner only when a requester transfer happens
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r <= SRC_ZERO;
        end else if (load_s) begin
            ptr_r <= next_ptr_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Count flits handed to the router; wraps naturally at 2^32
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_count_r <= 32'd0;
        end else if (drain_s) begin
            pkt_count_r <= pkt_count_r + 32'd1;
        end else begin
            pkt_count_r <= pkt_count_r;
        end
    end

    assign o_data       = data_r;
    assign o_data_valid = valid_r;
    assign o_src        = src_r;
    assign o_pkt_count  = pkt_count_r;

endmodule

// File: tb/tb_pe_port_arbiter.sv
// Directed self-checking bench for pe_port_arbiter (NUM_IN=4, DATA_W=32).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.

module tb_pe_port_arbiter;

    localparam int NUM_IN = 4;
    localparam int DATA_W = 32;
    localparam int SRC_W  = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_IN*DATA_W-1:0] i_data;
    logic [NUM_IN-1:0]        i_data_valid;
    logic [NUM_IN-1:0]        o_data_ready;
    logic [DATA_W-1:0]        o_data;
    logic                     o_data_valid;
    logic [SRC_W-1:0]         o_src;
    logic                     i_data_ready;
    logic [31:0]              o_pkt_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    pe_port_arbiter #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .SRC_W(SRC_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_data      (i_data),
        .i_data_valid(i_data_valid),
        .o_data_ready(o_data_ready),
        .o_data      (o_data),
        .o_data_valid(o_data_valid),
        .o_src       (o_src),
        .i_data_ready(i_data_ready),
        .o_pkt_count (o_pkt_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Flit k = destination k, payload k (plus a tag in the payload)
    task automatic load_flits(input logic [31:0] tag);
        for (int k = 0; k < NUM_IN; k++) begin
            i_data[k*DATA_W +: DATA_W] = (32'(k) << 24) | tag | 32'(k);
        end
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        i_data_valid = 4'b0000;
        i_data_ready = 1'b0;
        i_data       = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        i_data_valid = 4'b0000;
        i_data_ready = 1'b0;
        i_data       = '0;
        repeat (3) tick();
        total_cnt++;
        if (o_data_valid !== 1'b0) $display("FAIL reset_valid got %0b exp 0", o_data_valid);
        else pass_cnt++;
        total_cnt++;
        if (o_pkt_count !== 32'd0) $display("FAIL reset_count got %0d exp 0", o_pkt_count);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        total_cnt++;
        if (o_data_valid !== 1'b0) $display("FAIL idle_valid got %0b exp 0", o_data_valid);
        else pass_cnt++;
        total_cnt++;
        if (o_data_ready !== 4'b0000) $display("FAIL idle_ready got %b exp 0000", o_data_ready);
        else pass_cnt++;
        total_cnt++;
        if (o_data !== 32'h0 || o_src !== 2'd0) $display("FAIL idle_data got %h/%0d exp 0/0", o_data, o_src);
        else pass_cnt++;
    endtask

    task automatic test_single();
        do_reset();
        i_data[2*DATA_W +: DATA_W] = 32'h030000C8;
        i_data_valid = 4'b0100;
        i_data_ready = 1'b1;
        #1;
        total_cnt++;
        if (o_data_ready !== 4'b0100) $display("FAIL single_ready got %b exp 0100", o_data_ready);
        else pass_cnt++;
        tick();
        i_data_valid = 4'b0000;
        #1;
        total_cnt++;
        if (o_data !== 32'h030000C8) $display("FAIL single_data got %h exp 030000c8", o_data);
        else pass_cnt++;
        total_cnt++;
        if (o_src !== 2'd2 || o_data_valid !== 1'b1) $display("FAIL single_src got %0d/%0b exp 2/1", o_src, o_data_valid);
        else pass_cnt++;
        total_cnt++;
        if (o_pkt_count !== 32'd0 || o_data_ready !== 4'b0000) $display("FAIL single_pre_count got %0d/%b exp 0/0000", o_pkt_count, o_data_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (o_pkt_count !== 32'd1) $display("FAIL single_count got %0d exp 1", o_pkt_count);
        else pass_cnt++;
        total_cnt++;
        if (o_data_valid !== 1'b0 || o_data !== 32'h030000C8) $display("FAIL single_drain got %0b/%h exp 0/030000c8", o_data_valid, o_data);
        else pass_cnt++;
    endtask

    task automatic test_contention();
        logic [31:0] exp_data;
        logic [1:0]  exp_src;
        do_reset();
        load_flits(32'h0);
        i_data_valid = 4'b1111;
        i_data_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            exp_src  = 2'(c % 4);
            exp_data = (32'(c % 4) << 24) | 32'(c % 4);
            total_cnt++;
            if (o_src !== exp_src || o_data_valid !== 1'b1) $display("FAIL contention_src[%0d] got %0d/%0b exp %0d/1", c, o_src, o_data_valid, exp_src);
            else pass_cnt++;
            total_cnt++;
            if (o_data !== exp_data) $display("FAIL contention_data[%0d] got %h exp %h", c, o_data, exp_data);
            else pass_cnt++;
        end
        i_data_valid = 4'b0000;
        tick();
        total_cnt++;
        if (o_pkt_count !== 32'd8) $display("FAIL contention_count got %0d exp 8", o_pkt_count);
        else pass_cnt++;
    endtask

    task automatic test_back_pressure();
        do_reset();
        load_flits(32'h0000A000);
        i_data_valid = 4'b1111;
        i_data_ready = 1'b0;
        tick();
        total_cnt++;
        if (o_src !== 2'd0 || o_data_valid !== 1'b1) $display("FAIL bp_load got %0d/%0b exp 0/1", o_src, o_data_valid);
        else pass_cnt++;
        for (int c = 0; c < 5; c++) begin
            total_cnt++;
            if (o_data_ready !== 4'b0000) $display("FAIL bp_ready[%0d] got %b exp 0000", c, o_data_ready);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (o_src !== 2'd0 || o_data !== 32'h0000A000 || o_data_valid !== 1'b1)
                $display("FAIL bp_hold[%0d] got %0d/%h/%0b exp 0/0000a000/1", c, o_src, o_data, o_data_valid);
            else pass_cnt++;
        end
        total_cnt++;
        if (o_pkt_count !== 32'd0) $display("FAIL bp_count_stall got %0d exp 0", o_pkt_count);
        else pass_cnt++;
        i_data_ready = 1'b1;
        #1;
        total_cnt++;
        if (o_data_ready !== 4'b0010) $display("FAIL bp_release_ready got %b exp 0010", o_data_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (o_src !== 2'd1 || o_data !== 32'h0100A001) $display("FAIL bp_next got %0d/%h exp 1/0100a001", o_src, o_data);
        else pass_cnt++;
        total_cnt++;
        if (o_pkt_count !== 32'd1) $display("FAIL bp_count got %0d exp 1", o_pkt_count);
        else pass_cnt++;
    endtask

    task automatic test_skip_idle();
        logic [1:0] exp_src [4];
        logic [3:0] exp_rdy [4];
        exp_src = '{2'd3, 2'd1, 2'd3, 2'd1};
        exp_rdy = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
        do_reset();
        load_flits(32'h00005500);
        i_data_ready = 1'b1;
        i_data_valid = 4'b0010;
        tick();
        total_cnt++;
        if (o_src !== 2'd1) $display("FAIL skip_setup got %0d exp 1", o_src);
        else pass_cnt++;
        i_data_valid = 4'b1010;
        #1;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (o_data_ready !== exp_rdy[i]) $display("FAIL skip_ready[%0d] got %b exp %b", i, o_data_ready, exp_rdy[i]);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (o_src !== exp_src[i]) $display("FAIL skip_src[%0d] got %0d exp %0d", i, o_src, exp_src[i]);
            else pass_cnt++;
        end
        // Pointer must hold at 2 across idle cycles
        i_data_valid = 4'b0000;
        tick();
        tick();
        total_cnt++;
        if (o_data_valid !== 1'b0) $display("FAIL skip_idle_valid got %0b exp 0", o_data_valid);
        else pass_cnt++;
        i_data_valid = 4'b1111;
        tick();
        total_cnt++;
        if (o_src !== 2'd2) $display("FAIL skip_ptr_hold got %0d exp 2", o_src);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        load_flits(32'h00007700);
        i_data_valid = 4'b1111;
        i_data_ready = 1'b1;
        repeat (3) tick();
        i_data_ready = 1'b0;
        tick();
        total_cnt++;
        if (o_data_valid !== 1'b1 || o_pkt_count !== 32'd2) $display("FAIL mid_pre got %0b/%0d exp 1/2", o_data_valid, o_pkt_count);
        else pass_cnt++;
        #2;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (o_data_valid !== 1'b0 || o_pkt_count !== 32'd0) $display("FAIL mid_async got %0b/%0d exp 0/0", o_data_valid, o_pkt_count);
        else pass_cnt++;
        total_cnt++;
        if (o_data !== 32'h0 || o_src !== 2'd0) $display("FAIL mid_clear got %h/%0d exp 0/0", o_data, o_src);
        else pass_cnt++;
        #1;
        rst = 1'b1;
        i_data_ready = 1'b1;
        tick();
        total_cnt++;
        if (o_src !== 2'd0 || o_data !== 32'h00007700 || o_data_valid !== 1'b1)
            $display("FAIL mid_restart got %0d/%h/%0b exp 0/00007700/1", o_src, o_data, o_data_valid);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_back_pressure();
        test_skip_idle();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pe_port_arbiter.md
Name: pe_port_arbiter

Overview:
Round-robin arbiter that shares one router injection port between NUM_IN PE-side requesters.
- Packets are single 32-bit flits: [31:24] destination PE address, [23:0] payload.
- The block picks one valid requester per cycle, registers its flit into a one-entry output stage, and presents it to the router with a valid/ready handshake.
- It sits between a PE cluster and the local router port.
- It also counts forwarded packets for end-of-run reporting.

Parameters:
NUM_IN, 4, number of requesting PE ports (2..16)
DATA_W, 32, flit width; [DATA_W-1:DATA_W-8] is the destination address
SRC_W, 2, width of the source index; must equal clog2(NUM_IN)

Ports:
clk  input  1  clock, all state updates on its rising edge
rst  input  1  asynchronous, active-low reset; one clock domain
i_data  input  NUM_IN*DATA_W  requester flits; requester k occupies [k*DATA_W +: DATA_W]
i_data_valid  input  NUM_IN  per-requester valid
o_data_ready  output  NUM_IN  per-requester ready (combinational)
o_data  output  DATA_W  registered flit to router
o_data_valid  output  1  registered valid to router
o_src  output  SRC_W  index of the requester whose flit is in o_data
i_data_ready  input  1  router accepts o_data when high with o_data_valid
o_pkt_count  output  32  total flits accepted by the router since reset

Behaviour:
Reset (rst=0, asynchronous):
- o_data_valid=0, o_data=0, o_src=0, o_pkt_count=0, rr pointer=0.
- Takes effect immediately, mid-transfer included.
- A flit held in the output stage is discarded and is not counted.

Load enable:
- load_en = ~o_data_valid | i_data_ready.
- The output stage is free, or is being drained this cycle.

Grant (combinational):
- Scan requesters ptr, ptr+1, …, NUM_IN-1, 0, …, ptr-1, modulo NUM_IN.
- g = first index with i_data_valid[k]=1. If none is valid, there is no grant.

Ready:
- o_data_ready[k] = load_en & (k==g) & any_valid.
- At most one bit is high per cycle.
- o_data_ready must not depend on i_data_ready when o_data_valid=0.

Transfer from requester g: occurs on a clock edge where i_data_valid[g] & o_data_ready[g]. On that edge:
- o_data <= flit g, o_src <= g, o_data_valid <= 1.
- ptr <= (g+1) mod NUM_IN.

Drain without refill:
- If load_en and no requester is valid, o_data_valid <= 0.
- o_data and o_src hold their old values.

Pointer:
- Changes only on a requester transfer; it is unchanged on idle cycles and on stall cycles.
- Guarantees each continuously-valid requester is served within NUM_IN transfers.

Stall:
- o_data_valid=1 & i_data_ready=0 means o_data, o_src and o_data_valid hold stable.
- All o_data_ready bits are 0.

Simultaneous drain and fill:
- When i_data_ready=1, the stage drains and reloads in the same cycle.
- This gives full throughput of one flit per cycle.

Latency: one cycle from requester acceptance to o_data_valid.

Counter:
- o_pkt_count increments by 1 on each edge where o_data_valid & i_data_ready.
- Wraps from 2^32-1 to 0.

Requester protocol:
- Requesters hold i_data_valid and the flit stable until accepted.
- The arbiter does not latch requests; a valid dropped before grant is simply skipped.

Payload handling: no modification of the payload or destination field.

Test Plan:
- Reset then idle: rst low 3 cycles, all valids 0 → o_data_valid=0, o_pkt_count=0, o_data_ready=0000 after release.
- Single requester: req 2 valid with flit 0x03_0000C8, i_data_ready=1 → o_data_ready=0100 for one cycle; next cycle o_data=0x030000C8, o_src=2, o_data_valid=1; o_pkt_count=1 one cycle later.
- Full contention, 8 cycles: all 4 valid, flits 0x0X_00000k, i_data_ready=1 → o_src sequence 0,1,2,3,0,1,2,3, one flit per cycle, o_pkt_count=8.
- Back-pressure: all valid, i_data_ready=0 for 5 cycles after first load → o_data/o_src frozen, o_data_ready=0000 throughout; on i_data_ready=1, next source is (held src+1) mod 4.
- Skip idle requester: only reqs 1 and 3 valid, ptr=2 → grant order 3,1,3,1; ptr after each = 0,2,0,2.
- Reset mid-stall: o_data_valid=1, i_data_ready=0, rst pulsed low between edges → o_data_valid=0 and o_pkt_count=0 immediately; after release the arbiter restarts from requester 0.
